// File: rtl/console_pkg.sv
// Shared constants, state encoding and byte classification
// for the text-console controller.
package console_pkg;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LEFT  = 8'h11;
  localparam logic [7:0] CH_RIGHT = 8'h12;
  localparam logic [7:0] CH_UP    = 8'h13;
  localparam logic [7:0] CH_DOWN  = 8'h14;
  localparam logic [7:0] CH_DEL   = 8'h7F;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/console_addr.sv
// Logical (row, col) to video RAM address through the
// circular row base; one wrap-subtract, no general modulo.
module console_addr #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int AW   = 13
) (
  input  logic [YW-1:0] row,
  input  logic [XW-1:0] col,
  input  logic [YW-1:0] base,
  output logic [AW-1:0] addr
);

  logic [YW:0]   sum;
  logic [YW:0]   wrapped;
  logic [YW-1:0] phys;

  always_comb begin
    sum     = {1'b0, base} + {1'b0, row};
    wrapped = sum;
    if (sum >= (YW+1)'(ROWS))
      wrapped = sum - (YW+1)'(ROWS);
    phys = wrapped[YW-1:0];
    addr = AW'(phys) * AW'(COLS) + AW'(col);
  end

endmodule

// File: rtl/console_ctrl.sv
// Byte-stream console: cursor control, VRAM writes,
// hardware scroll via row_base, line/screen clear.
module console_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int TAB  = 8,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int AW   = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcv,
  input  logic [7:0]    data_i,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic [YW-1:0] row_base,
  output logic          write,
  output logic [AW-1:0] addr_vram,
  output logic [7:0]    character,
  output logic          busy,
  output logic          overrun
);

  import console_pkg::*;

  localparam logic [XW-1:0] XMAX  = XW'(COLS-1);
  localparam logic [YW-1:0] YMAX  = YW'(ROWS-1);
  localparam logic [AW-1:0] AMAX  = AW'(COLS*ROWS-1);
  localparam logic [XW:0]   TMASK = (XW+1)'(TAB-1);

  state_t        state;
  logic [XW-1:0] clr_col;
  logic [AW-1:0] clr_cnt;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] line_addr;
  logic [XW:0]   tab_x;
  logic          is_bs;
  logic          take;
  logic          do_nl;

  // Backspace addresses the cell it moves onto, not the current one.
  always_comb begin
    is_bs = (data_i == CH_BS) || (data_i == CH_DEL);
    wx    = cursor_x;
    wy    = cursor_y;
    if (is_bs) begin
      if (cursor_x != '0) begin
        wx = cursor_x - 1'b1;
      end else begin
        wx = XMAX;
        wy = cursor_y - 1'b1;
      end
    end
    tab_x = ({1'b0, cursor_x} | TMASK) + 1'b1;
    take  = rcv && !busy && (state == IDLE);
    do_nl = take && ((is_print(data_i) && cursor_x == XMAX)
                     || data_i == CH_LF);
  end

  console_addr #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .AW(AW)
  ) u_cur (
    .row (wy),
    .col (wx),
    .base(row_base),
    .addr(cur_addr)
  );

  // After a scroll the freshly exposed row is the bottom logical row.
  console_addr #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .AW(AW)
  ) u_line (
    .row (YMAX),
    .col (clr_col),
    .base(row_base),
    .addr(line_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cursor_x  <= '0;
      cursor_y  <= '0;
      row_base  <= '0;
      write     <= 1'b0;
      addr_vram <= '0;
      character <= 8'h00;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      clr_col   <= '0;
      clr_cnt   <= '0;
    end else begin
      write   <= 1'b0;
      overrun <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (rcv && busy) begin
            overrun <= 1'b1;
          end else if (take) begin
            unique case (1'b1)
              is_print(data_i): begin
                write     <= 1'b1;
                addr_vram <= cur_addr;
                character <= data_i;
                cursor_x  <= (cursor_x == XMAX) ? '0
                             : cursor_x + 1'b1;
              end
              data_i == CH_LF: cursor_x <= '0;
              data_i == CH_CR: cursor_x <= '0;
              is_bs: begin
                if (cursor_x != '0 || cursor_y != '0) begin
                  cursor_x  <= wx;
                  cursor_y  <= wy;
                  write     <= 1'b1;
                  addr_vram <= cur_addr;
                  character <= 8'h00;
                end
              end
              data_i == CH_TAB:
                cursor_x <= (tab_x > {1'b0, XMAX}) ? XMAX
                            : tab_x[XW-1:0];
              data_i == CH_LEFT:
                if (cursor_x != '0) cursor_x <= cursor_x - 1'b1;
              data_i == CH_RIGHT:
                if (cursor_x != XMAX) cursor_x <= cursor_x + 1'b1;
              data_i == CH_UP:
                if (cursor_y != '0) cursor_y <= cursor_y - 1'b1;
              data_i == CH_DOWN:
                if (cursor_y != YMAX) cursor_y <= cursor_y + 1'b1;
              data_i == CH_FF: begin
                state   <= CLR_SCREEN;
                busy    <= 1'b1;
                clr_cnt <= '0;
              end
              default: ;
            endcase
          end
          if (do_nl) begin
            if (cursor_y != YMAX) begin
              cursor_y <= cursor_y + 1'b1;
            end else begin
              row_base <= (row_base == YMAX) ? '0
                          : row_base + 1'b1;
              state    <= CLR_LINE;
              busy     <= 1'b1;
              clr_col  <= '0;
            end
          end
        end
        CLR_LINE: begin
          if (rcv) overrun <= 1'b1;
          write     <= 1'b1;
          addr_vram <= line_addr;
          character <= 8'h00;
          clr_col   <= clr_col + 1'b1;
          if (clr_col == XMAX) state <= IDLE;
        end
        CLR_SCREEN: begin
          if (rcv) overrun <= 1'b1;
          write     <= 1'b1;
          addr_vram <= clr_cnt;
          character <= 8'h00;
          clr_cnt   <= clr_cnt + 1'b1;
          if (clr_cnt == AMAX) begin
            state    <= IDLE;
            cursor_x <= '0;
            cursor_y <= '0;
            row_base <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_console_ctrl.sv
// Directed-vector bench for console_ctrl at 40x30.
module tb_console_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rcv = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [4:0]  row_base;
  logic        write;
  logic [12:0] addr_vram;
  logic [7:0]  character;
  logic        busy;
  logic        overrun;

  int vecs = 0;
  int errs = 0;

  console_ctrl #(.COLS(40), .ROWS(30), .TAB(8), .AW(13)) dut (
    .clk      (clk),
    .rst      (rst),
    .rcv      (rcv),
    .data_i   (data_i),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .row_base (row_base),
    .write    (write),
    .addr_vram(addr_vram),
    .character(character),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rcv    = 1'b1;
    data_i = b;
    @(negedge clk);
    rcv = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    vecs++;
    if ({cursor_x, cursor_y, row_base} !== 16'h0) begin
      errs++;
      $display("FAIL reset_cursor x=%0d y=%0d rb=%0d want 0",
               cursor_x, cursor_y, row_base);
    end
    vecs++;
    if ({write, busy, overrun} !== 3'b000) begin
      errs++;
      $display("FAIL reset_flags w/b/o=%b want 000",
               {write, busy, overrun});
    end
    vecs++;
    if (addr_vram !== 13'd0 || character !== 8'h00) begin
      errs++;
      $display("FAIL reset_bus addr=%0d ch=%h want 0/00",
               addr_vram, character);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_print;
    send(8'h41);
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd0 ||
        character !== 8'h41 || cursor_x !== 6'd1) begin
      errs++;
      $display("FAIL print_A w=%b a=%0d ch=%h x=%0d want 1/0/41/1",
               write, addr_vram, character, cursor_x);
    end
    @(negedge clk);
    vecs++;
    if (write !== 1'b0) begin
      errs++;
      $display("FAIL print_one_shot write=%b want 0", write);
    end
  endtask

  task automatic test_wrap;
    send(8'h0D);
    repeat (39) send(8'h12);
    repeat (5) send(8'h14);
    vecs++;
    if (cursor_x !== 6'd39 || cursor_y !== 5'd5) begin
      errs++;
      $display("FAIL wrap_setup x=%0d y=%0d want 39/5",
               cursor_x, cursor_y);
    end
    send(8'h5A);
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd239 ||
        character !== 8'h5A) begin
      errs++;
      $display("FAIL wrap_write w=%b a=%0d ch=%h want 1/239/5a",
               write, addr_vram, character);
    end
    vecs++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd6 ||
        row_base !== 5'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL wrap_cursor x=%0d y=%0d rb=%0d b=%b want 0/6/0/0",
               cursor_x, cursor_y, row_base, busy);
    end
  endtask

  task automatic test_scroll;
    int n;
    logic seq_bad;
    repeat (30) send(8'h14);
    vecs++;
    if (cursor_y !== 5'd29) begin
      errs++;
      $display("FAIL down_sat y=%0d want 29", cursor_y);
    end
    repeat (3) send(8'h12);
    send(8'h0A);
    vecs++;
    if (row_base !== 5'd1 || cursor_x !== 6'd0 ||
        cursor_y !== 5'd29 || busy !== 1'b1) begin
      errs++;
      $display("FAIL scroll_enter rb=%0d x=%0d y=%0d b=%b want 1/0/29/1",
               row_base, cursor_x, cursor_y, busy);
    end
    n = 0;
    seq_bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) break;
      if (write) begin
        if (addr_vram !== 13'(n) || character !== 8'h00)
          seq_bad = 1'b1;
        n++;
      end
    end
    vecs++;
    if (seq_bad || n != 40 || busy !== 1'b0) begin
      errs++;
      $display("FAIL clr_line writes=%0d bad=%b busy=%b want 40/0/0",
               n, seq_bad, busy);
    end
    send(8'h42);
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd0 ||
        character !== 8'h42 || cursor_x !== 6'd1) begin
      errs++;
      $display("FAIL after_scroll w=%b a=%0d ch=%h x=%0d want 1/0/42/1",
               write, addr_vram, character, cursor_x);
    end
  endtask

  task automatic test_clear_screen;
    int n;
    int ov;
    logic seq_bad;
    send(8'h0C);
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL ff_busy busy=%b want 1", busy);
    end
    n = 0;
    ov = 0;
    seq_bad = 1'b0;
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      rcv = 1'b0;
      if (!busy) break;
      if (write) begin
        if (addr_vram !== 13'(n) || character !== 8'h00)
          seq_bad = 1'b1;
        n++;
      end
      if (overrun) ov++;
      if (c == 100) begin
        rcv    = 1'b1;
        data_i = 8'h51;
      end
    end
    vecs++;
    if (seq_bad || n != 1200) begin
      errs++;
      $display("FAIL clr_screen writes=%0d bad=%b want 1200/0",
               n, seq_bad);
    end
    vecs++;
    if (ov != 1) begin
      errs++;
      $display("FAIL overrun pulses=%0d want 1", ov);
    end
    vecs++;
    if (cursor_x !== 6'd0 || cursor_y !== 5'd0 ||
        row_base !== 5'd0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ff_final x=%0d y=%0d rb=%0d b=%b want 0/0/0/0",
               cursor_x, cursor_y, row_base, busy);
    end
  endtask

  task automatic test_backspace;
    repeat (2) send(8'h14);
    send(8'h7F);
    vecs++;
    if (cursor_x !== 6'd39 || cursor_y !== 5'd1 || write !== 1'b1 ||
        addr_vram !== 13'd79 || character !== 8'h00) begin
      errs++;
      $display("FAIL bs_wrap x=%0d y=%0d w=%b a=%0d ch=%h want 39/1/1/79/00",
               cursor_x, cursor_y, write, addr_vram, character);
    end
    send(8'h08);
    vecs++;
    if (cursor_x !== 6'd38 || write !== 1'b1 ||
        addr_vram !== 13'd78) begin
      errs++;
      $display("FAIL bs_mid x=%0d w=%b a=%0d want 38/1/78",
               cursor_x, write, addr_vram);
    end
    send(8'h0D);
    send(8'h13);
    send(8'h08);
    vecs++;
    if (write !== 1'b0 || cursor_x !== 6'd0 || cursor_y !== 5'd0) begin
      errs++;
      $display("FAIL bs_origin w=%b x=%0d y=%0d want 0/0/0",
               write, cursor_x, cursor_y);
    end
  endtask

  task automatic test_tab;
    repeat (5) send(8'h12);
    send(8'h09);
    vecs++;
    if (cursor_x !== 6'd8 || write !== 1'b0) begin
      errs++;
      $display("FAIL tab_5 x=%0d w=%b want 8/0", cursor_x, write);
    end
    repeat (29) send(8'h12);
    send(8'h09);
    vecs++;
    if (cursor_x !== 6'd39) begin
      errs++;
      $display("FAIL tab_37 x=%0d want 39", cursor_x);
    end
    send(8'h12);
    vecs++;
    if (cursor_x !== 6'd39) begin
      errs++;
      $display("FAIL right_sat x=%0d want 39", cursor_x);
    end
    send(8'h13);
    vecs++;
    if (cursor_y !== 5'd0) begin
      errs++;
      $display("FAIL up_sat y=%0d want 0", cursor_y);
    end
    send(8'h01);
    vecs++;
    if (write !== 1'b0 || cursor_x !== 6'd39 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ignored w=%b x=%0d b=%b want 0/39/0",
               write, cursor_x, busy);
    end
    send(8'h0D);
    send(8'h11);
    vecs++;
    if (cursor_x !== 6'd0) begin
      errs++;
      $display("FAIL left_sat x=%0d want 0", cursor_x);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    rcv    = 1'b1;
    data_i = 8'h43;
    @(negedge clk);
    data_i = 8'h44;
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd0 || character !== 8'h43) begin
      errs++;
      $display("FAIL b2b_first w=%b a=%0d ch=%h want 1/0/43",
               write, addr_vram, character);
    end
    @(negedge clk);
    rcv = 1'b0;
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd1 ||
        character !== 8'h44 || cursor_x !== 6'd2) begin
      errs++;
      $display("FAIL b2b_second w=%b a=%0d ch=%h x=%0d want 1/1/44/2",
               write, addr_vram, character, cursor_x);
    end
  endtask

  task automatic test_reset_abort;
    send(8'h0C);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vecs++;
    if (busy !== 1'b0 || write !== 1'b0 || addr_vram !== 13'd0 ||
        cursor_x !== 6'd0) begin
      errs++;
      $display("FAIL abort b=%b w=%b a=%0d x=%0d want 0/0/0/0",
               busy, write, addr_vram, cursor_x);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h45);
    vecs++;
    if (write !== 1'b1 || addr_vram !== 13'd0 || character !== 8'h45) begin
      errs++;
      $display("FAIL post_abort w=%b a=%0d ch=%h want 1/0/45",
               write, addr_vram, character);
    end
  endtask

  initial begin
    test_reset;
    test_print;
    test_wrap;
    test_scroll;
    test_clear_screen;
    test_backspace;
    test_tab;
    test_back_to_back;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/console_ctrl.md
Name: console_ctrl

Overview:
- Clocked, parametrised text-console controller between the UART receive path and the character video RAM.
- Interprets a byte stream (printable characters and control codes) and drives the cursor position and video RAM write strobes.
- Adds hardware scrolling through a circular row base, plus line-clear and screen-clear sequencers.
- Exports `row_base` so the video scan-out can rotate rows.

Parameters:
- COLS, 40, characters per row (640/glyph size; 40 for 16-px glyphs).
- ROWS, 30, rows per page.
- TAB, 8, tab stop spacing (power of 2).
- XW, $clog2(COLS), cursor_x width.
- YW, $clog2(ROWS), cursor_y / row_base width.
- AW, 13, video RAM address width. Must satisfy COLS*ROWS <= 2^AW.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rcv  in  1  one-cycle strobe: data_i valid.
- data_i  in  8  received byte.
- cursor_x  out  XW  logical cursor column.
- cursor_y  out  YW  logical cursor row (0 = top of visible page).
- row_base  out  YW  physical RAM row shown at screen top.
- write  out  1  video RAM write enable, one cycle per write.
- addr_vram  out  AW  video RAM address.
- character  out  8  video RAM write data.
- busy  out  1  sequencer running; rcv not accepted.
- overrun  out  1  one-cycle pulse when rcv arrives while busy (byte dropped).

Behaviour:
- Reset (async on rst high): cursor_x=0, cursor_y=0, row_base=0, write=0, addr_vram=0, character=0, busy=0, overrun=0, state=IDLE.
- All outputs are registered. addr = phys_row*COLS + col, where phys_row = row_base+row, subtracting ROWS if the sum is >= ROWS (no wider modulo).
- States:
  - IDLE: rcv=1 decodes data_i; results appear on the next edge.
  - CLR_LINE: clears one row.
  - CLR_SCREEN: clears the whole page.
- Decode in IDLE (rcv at edge n, all effects visible after edge n+1):
  - 0x20..0x7E: write=1, addr=current cursor, character=data_i; cursor_x+1.
    - If cursor_x was COLS-1: cursor_x=0 and a newline is applied.
  - 0x0A (LF): cursor_x=0, newline.
  - 0x0D (CR): cursor_x=0 only.
  - 0x08 or 0x7F (backspace):
    - If cursor_x>0: cursor_x-1, write=1, character=0x00 at the new position.
    - At cursor_x=0 with cursor_y>0: go to (COLS-1, y-1) and erase there.
    - At (0,0): no write, no move.
  - 0x09 (TAB): cursor_x rounded up to the next multiple of TAB, saturating at COLS-1; no write.
  - 0x11/0x12 (left/right): cursor_x ∓1, saturating at 0 / COLS-1.
  - 0x13/0x14 (up/down): cursor_y ∓1, saturating at 0 / ROWS-1; no scroll.
  - 0x0C (form feed): enter CLR_SCREEN.
  - Any other byte: ignored. No write, no state change.
- Newline rule:
  - If cursor_y<ROWS-1: cursor_y+1.
  - Otherwise scroll: row_base+1 mod ROWS, cursor_y stays ROWS-1, enter CLR_LINE for the new bottom physical row.
- CLR_LINE:
  - busy=1; writes 0x00 to col 0..COLS-1 of the target row, one per cycle (COLS cycles, write=1 each).
  - Then IDLE, busy=0.
  - The triggering character write, if any, completes on the cycle before CLR_LINE's first write.
- CLR_SCREEN:
  - busy=1; writes 0x00 to addr 0..COLS*ROWS-1 sequentially.
  - Then cursor=(0,0), row_base=0, IDLE.
- busy asserts on the edge that enters a clear state and deasserts on the edge after the last clear write.
- While busy=1, rcv=1 pulses overrun on the next edge; state is otherwise unaffected.
- rst asserted mid-clear aborts immediately to reset values. Partial clear is acceptable.
- write is never high in two consecutive cycles in IDLE unless rcv strobes are back to back. Back-to-back rcv in IDLE is legal and each byte is processed.

Decomposition:
- console_pkg holds:
  - control code constants: CH_LF, CH_CR, CH_BS, CH_DEL, CH_TAB, CH_FF, CH_LEFT, CH_RIGHT, CH_UP, CH_DOWN;
  - the state enum (IDLE, CLR_LINE, CLR_SCREEN);
  - a printable-range function.
- One sub-module, console_addr: combinational (row, col, row_base) -> addr with the wrap-subtract, instanced for both the cursor path and the clear-sequencer path.

Test Plan (COLS=40, ROWS=30):
- Reset, then rcv 'A'(0x41) → next cycle: write=1, addr=0, character=0x41, cursor_x=1.
- Cursor at (39,5), rcv 'Z' → write addr=239, then cursor=(0,6), no scroll, busy=0.
- Cursor at (3,29), rcv 0x0A → row_base=1, cursor=(0,29), busy=1 for 40 cycles, writes 0x00 to addr 0..39. Next 'B' writes addr 0.
- rcv 0x0C → 1200 consecutive writes to addr 0..1199 with 0x00. A rcv mid-clear gives one overrun pulse. Final cursor=(0,0), row_base=0.
- Cursor at (0,2), rcv 0x7F → cursor=(39,1), write addr=79, character=0. At (0,0), 0x08 produces no write.
- Cursor x=5, rcv 0x09 → x=8. At x=37, 0x09 → x=39. 0x12 at x=39 stays 39. 0x13 at y=0 stays 0.
